mmio_bridge: RTL and testbench

//  Parametrised data-memory splitter between processor dmem port and RAM.

---
 rtl/mmio_defs.sv | 21 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/mmio_bridge.sv | 153 +++++++++++++++
 tb/tb_mmio_bridge.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_defs.sv
// Shared MMIO definitions for the dmem peripheral window: register offsets,
// the default window base and the registered read-select record.
package mmio_defs;

   // Word offsets inside the 16-word peripheral window
   localparam logic [3:0] MMIO_LED   = 4'd0;
   localparam logic [3:0] MMIO_LEVEL = 4'd1;
   localparam logic [3:0] MMIO_EDGE  = 4'd2;
   localparam logic [3:0] MMIO_FRAME = 4'd3;
   localparam logic [3:0] MMIO_TIMER = 4'd4;

   // Default base of the window: top 16 words of a 12-bit dmem space
   localparam logic [11:0] MMIO_PERIPH_BASE = 12'hFF0;

   // What the read data of the previous cycle should come from
   typedef struct packed {
      logic       hit;   // 1 = peripheral window, 0 = RAM
      logic [3:0] off;   // register offset when hit
   } rsel_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser, stability counter,
// debounced level and a one-cycle pulse on the level's 0->1 transition.
module btn_debounce #(
   parameter int DEB_CYC = 50000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sync;

   assign sync = sync_q[1];

   // Pulse in the same cycle the level register is about to flip to 1
   assign rise = sync & ~level & (cnt_q == CNT_MAX);

   // Synchronise raw input, then accept a new level only after DEB_CYC stable cycles
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         level  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         if (sync == level) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            level <= sync;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmio_bridge.sv
// Data-memory splitter between the processor dmem port and RAM, with a
// 16-word peripheral window (LED, debounced buttons, sticky press flags,
// VGA frame counter). Optional feature macro: MMIO_TIMER_EN adds a
// free-running 32-bit cycle counter at offset 4.
module mmio_bridge
   import mmio_defs::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int N_BTN   = 4,
   parameter int LED_W   = 16,
   parameter int DEB_CYC = 50000,
   parameter logic [ADDR_W-1:0] PERIPH_BASE = ADDR_W'(MMIO_PERIPH_BASE)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic [N_BTN-1:0]  btn_raw,
   input  logic              vsync,
   output logic [LED_W-1:0]  led
);

   // ---------------- decode ----------------
   logic       hit;
   logic [3:0] off;
   logic       wr_led, wr_edge, wr_frame;

   assign hit      = (cpu_addr[ADDR_W-1:4] == PERIPH_BASE[ADDR_W-1:4]);
   assign off      = cpu_addr[3:0];
   assign wr_led   = cpu_we & hit & (off == MMIO_LED);
   assign wr_edge  = cpu_we & hit & (off == MMIO_EDGE);
   assign wr_frame = cpu_we & hit & (off == MMIO_FRAME);

   assign ram_addr  = cpu_addr;
   assign ram_wdata = cpu_wdata;
   assign ram_we    = cpu_we & ~hit;

   // Write-data bits above the widest register have no destination
   logic unused_wdata;
   assign unused_wdata = ^cpu_wdata;

   // ---------------- buttons ----------------
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] edge_q;
   logic [N_BTN-1:0] edge_clr;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .clock   (clock),
         .reset_n (reset_n),
         .raw     (btn_raw[i]),
         .level   (level[i]),
         .rise    (rise[i])
      );
   end

   assign edge_clr = wr_edge ? cpu_wdata[N_BTN-1:0] : '0;

   // Sticky press flags: a new rise overrides a same-cycle write-1-to-clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) edge_q <= '0;
      else          edge_q <= (edge_q & ~edge_clr) | rise;
   end

   // LED register, loaded from the low write-data bits
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    led <= '0;
      else if (wr_led) led <= cpu_wdata[LED_W-1:0];
   end

   // ---------------- frame counter ----------------
   logic        vs_s1, vs_s2, vs_d;
   logic [31:0] frame_q;

   // Synchronise vsync, count its rising edges; a write clears and beats a same-cycle edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vs_s1   <= 1'b0;
         vs_s2   <= 1'b0;
         vs_d    <= 1'b0;
         frame_q <= '0;
      end else begin
         vs_s1 <= vsync;
         vs_s2 <= vs_s1;
         vs_d  <= vs_s2;
         if (wr_frame)           frame_q <= '0;
         else if (vs_s2 & ~vs_d) frame_q <= frame_q + 32'd1;
      end
   end

   // ---------------- optional cycle timer ----------------
`ifdef MMIO_TIMER_EN
   logic [31:0] timer_q;
   logic        wr_timer;

   assign wr_timer = cpu_we & hit & (off == MMIO_TIMER);

   // Free-running cycle counter; a write loads it and counting resumes from there
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)      timer_q <= '0;
      else if (wr_timer) timer_q <= 32'(cpu_wdata);
      else               timer_q <= timer_q + 32'd1;
   end
`endif

   // ---------------- read path ----------------
   logic [DATA_W-1:0] periph_rdata_d;
   logic [DATA_W-1:0] periph_rdata_q;
   rsel_t             rsel_q;
   logic              rd_vld_q;

   // Peripheral read mux on the current address; unmapped offsets read zero
   // NOTE: the default assignment up front keeps this combinational block from inferring a latch.
   always_comb begin
      periph_rdata_d = '0;
      case (off)
         MMIO_LED:   periph_rdata_d = DATA_W'(led);
         MMIO_LEVEL: periph_rdata_d = DATA_W'(level);
         MMIO_EDGE:  periph_rdata_d = DATA_W'(edge_q);
         MMIO_FRAME: periph_rdata_d = DATA_W'(frame_q);
`ifdef MMIO_TIMER_EN
         MMIO_TIMER: periph_rdata_d = DATA_W'(timer_q);
`endif
         default:    periph_rdata_d = '0;
      endcase
   end

   // Register the source select and peripheral data to line up with the RAM's 1-cycle latency
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsel_q         <= '{hit: 1'b0, off: 4'd0};
         periph_rdata_q <= '0;
         rd_vld_q       <= 1'b0;
      end else begin
         rsel_q         <= '{hit: hit, off: off};
         periph_rdata_q <= periph_rdata_d;
         rd_vld_q       <= 1'b1;
      end
   end

   // Until an address has been sampled after reset there is nothing valid to return
   assign cpu_rdata = !rd_vld_q  ? '0 :
                      rsel_q.hit ? periph_rdata_q : ram_rdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with DEB_CYC=8: a vector table for the
// decode/read path plus hand sequences for debounce, edge flags, frame
// counter, asynchronous reset and the optional timer (MMIO_TIMER_EN).
module tb_mmio_bridge;

   localparam int DEB = 8;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [11:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_we;
   logic [31:0] cpu_rdata;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_we;
   logic [31:0] ram_rdata;
   logic [3:0]  btn_raw;
   logic        vsync;
   logic [15:0] led;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   mmio_bridge #(
      .ADDR_W(12), .DATA_W(32), .N_BTN(4), .LED_W(16), .DEB_CYC(DEB)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we    (cpu_we),
      .cpu_rdata (cpu_rdata),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .btn_raw   (btn_raw),
      .vsync     (vsync),
      .led       (led)
   );

   // Synchronous RAM model, read-before-write, 1-cycle latency
   logic [31:0] mem [0:4095];
   always @(posedge clock) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        exp_ram_we;
      logic        chk;
      logic [31:0] exp_rdata;
      logic [15:0] exp_led;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      cpu_addr  = addr;
      cpu_wdata = data;
      cpu_we    = 1'b1;
      cyc();
      cpu_we    = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
      cpu_addr = addr;
      cpu_we   = 1'b0;
      cyc();
      check(name, cpu_rdata, exp);
   endtask

   // Call right after the raw press edge; LEVEL must flip exactly 2+DEB cycles later
   task automatic level_latency(input string tag, input int elapsed);
      cpu_addr = 12'hFF1;
      cpu_we   = 1'b0;
      repeat (DEB + 2 - elapsed) cyc();
      check({tag, "_level_early"}, cpu_rdata, 32'h0);
      cyc();
      check({tag, "_level_on"}, cpu_rdata, 32'h2);
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      repeat (3) cyc();
      vsync = 1'b0;
      repeat (3) cyc();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;

      //            we    addr     wdata         ramwe chk   rdata         led
      vecs[0]  = '{1'b1, 12'h010, 32'h12345678, 1'b1, 1'b0, 32'h00000000, 16'h0000};
      vecs[1]  = '{1'b0, 12'h010, 32'h0,        1'b0, 1'b1, 32'h12345678, 16'h0000};
      vecs[2]  = '{1'b1, 12'hFF0, 32'hFFFFA5A5, 1'b0, 1'b1, 32'h00000000, 16'hA5A5};
      vecs[3]  = '{1'b0, 12'hFF0, 32'h0,        1'b0, 1'b1, 32'h0000A5A5, 16'hA5A5};
      vecs[4]  = '{1'b0, 12'h010, 32'h0,        1'b0, 1'b1, 32'h12345678, 16'hA5A5};
      vecs[5]  = '{1'b1, 12'hFEF, 32'h0BADF00D, 1'b1, 1'b0, 32'h00000000, 16'hA5A5};
      vecs[6]  = '{1'b0, 12'hFEF, 32'h0,        1'b0, 1'b1, 32'h0BADF00D, 16'hA5A5};
      vecs[7]  = '{1'b0, 12'hFF5, 32'h0,        1'b0, 1'b1, 32'h00000000, 16'hA5A5};
      vecs[8]  = '{1'b1, 12'hFF7, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00000000, 16'hA5A5};
      vecs[9]  = '{1'b0, 12'hFF1, 32'h0,        1'b0, 1'b1, 32'h00000000, 16'hA5A5};
      vecs[10] = '{1'b0, 12'hFF2, 32'h0,        1'b0, 1'b1, 32'h00000000, 16'hA5A5};
      vecs[11] = '{1'b0, 12'hFF3, 32'h0,        1'b0, 1'b1, 32'h00000000, 16'hA5A5};
      vecs[12] = '{1'b1, 12'hFF0, 32'h00001234, 1'b0, 1'b1, 32'h0000A5A5, 16'h1234};
      vecs[13] = '{1'b0, 12'hFF0, 32'h0,        1'b0, 1'b1, 32'h00001234, 16'h1234};

      reset_n   = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_we    = 1'b0;
      btn_raw   = '0;
      vsync     = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_led", 32'(led), 32'h0);
      check("reset_rdata", cpu_rdata, 32'h0);
      reset_n = 1'b1;
      cyc();

      // Decode and read-path vectors
      for (int i = 0; i < 14; i++) begin
         cpu_we    = vecs[i].we;
         cpu_addr  = vecs[i].addr;
         cpu_wdata = vecs[i].wdata;
         #1;
         check($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].exp_ram_we));
         @(posedge clock);
         #1;
         if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      end
      cpu_we = 1'b0;
      check("ram_window_untouched", mem[12'hFF0], 32'h0);

      // Short glitch never changes the level
      btn_raw = 4'b0010;
      repeat (5) cyc();
      btn_raw = 4'b0000;
      repeat (12) cyc();
      rd_chk("glitch_level", 12'hFF1, 32'h0);
      rd_chk("glitch_edge", 12'hFF2, 32'h0);

      // Held press: exact latency, sticky flag, W1C
      btn_raw = 4'b0010;
      level_latency("press", 0);
      repeat (9) cyc();
      rd_chk("press_edge", 12'hFF2, 32'h2);
      rd_chk("press_level", 12'hFF1, 32'h2);
      wr(12'hFF2, 32'h2);
      rd_chk("edge_w1c", 12'hFF2, 32'h0);

      // Release sets no flag
      btn_raw = 4'b0000;
      repeat (14) cyc();
      rd_chk("release_level", 12'hFF1, 32'h0);
      rd_chk("release_edge", 12'hFF2, 32'h0);

      // New press lands on the same edge as a W1C of that bit: set wins
      btn_raw = 4'b0010;
      repeat (DEB + 1) cyc();
      wr(12'hFF2, 32'h2);
      rd_chk("edge_set_wins", 12'hFF2, 32'h2);
      wr(12'hFF2, 32'h1);
      rd_chk("edge_w1c_other_bit", 12'hFF2, 32'h2);

      // Frame counter
      repeat (3) vs_pulse();
      rd_chk("frame_three", 12'hFF3, 32'd3);
      wr(12'hFF3, 32'h0);
      rd_chk("frame_clear", 12'hFF3, 32'h0);
      force dut.frame_q = 32'hFFFF_FFFE;
      #1;
      release dut.frame_q;
      vs_pulse();
      rd_chk("frame_max", 12'hFF3, 32'hFFFF_FFFF);
      vs_pulse();
      rd_chk("frame_wrap", 12'hFF3, 32'h0);
      vs_pulse();
      rd_chk("frame_one", 12'hFF3, 32'd1);
      vsync = 1'b1;
      repeat (2) cyc();
      wr(12'hFF3, 32'h0);
      vsync = 1'b0;
      repeat (3) cyc();
      rd_chk("frame_clear_wins", 12'hFF3, 32'h0);

      // Asynchronous reset in the middle of a debounce count
      wr(12'hFF0, 32'h0000A5A5);
      vs_pulse();
      rd_chk("pre_reset_frame", 12'hFF3, 32'd1);
      btn_raw = 4'b0000;
      repeat (14) cyc();
      btn_raw = 4'b0010;
      repeat (4) cyc();
      cpu_addr = 12'h010;
      cyc();
      check("pre_reset_rdata", cpu_rdata, 32'h12345678);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_led", 32'(led), 32'h0);
      check("async_reset_rdata", cpu_rdata, 32'h0);
      reset_n = 1'b1;
      rd_chk("post_reset_edge_clear", 12'hFF2, 32'h0);
      rd_chk("post_reset_frame", 12'hFF3, 32'h0);
      rd_chk("post_reset_led", 12'hFF0, 32'h0);
      level_latency("post_reset", 3);
      repeat (4) cyc();
      rd_chk("post_reset_edge_set", 12'hFF2, 32'h2);

      // Optional cycle timer
`ifdef MMIO_TIMER_EN
      wr(12'hFF4, 32'd100);
      repeat (5) cyc();
      rd_chk("timer_count", 12'hFF4, 32'd105);
`else
      wr(12'hFF4, 32'd100);
      repeat (5) cyc();
      rd_chk("timer_absent", 12'hFF4, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
